breg_wbq: RTL and testbench
===========================

Name: breg_wbq

Overview:
- Writeback queue sitting directly upstream of the banked register file (breg).
- Accepts write requests from the execute stage through a valid/ready handshake and buffers up to DEPTH of them.
- Drains one request per cycle into breg's write port (w, y, wa, wval, mask), in order.
- Reports read-after-write hazards for a probe address, including breg's low-to-high mirroring: a write to address a<8 also writes a+8.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two, 2..16.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  upstream write request valid
- in_ready  out  1  queue can accept a request this cycle
- in_y  in  1  request mode: 1 = overwrite, 0 = XOR into current value
- in_wa  in  4  request register address
- in_wval  in  `WORD  request data
- in_mask  in  `WORD  request bit mask
- hold  in  1  when 1, stall draining; pushes still allowed
- w  out  1  write strobe to breg
- y  out  1  mode to breg
- wa  out  4  address to breg
- wval  out  `WORD  data to breg
- mask  out  `WORD  mask to breg
- chk_a  in  4  probe read address
- chk_hit  out  1  probe address has a pending write
- empty  out  1  queue holds no entries
- count  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Storage: circular buffer of DEPTH entries {y, wa, wval, mask}, with head pointer, tail pointer and count register.
- Push: occurs when in_valid && in_ready. Entry is written at tail; tail increments modulo DEPTH.
- in_ready = (count < DEPTH). It is computed from registered count only. A full queue does not accept a push in the same cycle as a pop.
- Pop: w = (count != 0) && !hold, computed combinationally from registered state. The pop takes effect at the clock edge where w=1; head increments modulo DEPTH.
- Outputs when count != 0: y/wa/wval/mask present the head entry fields, whether or not hold is asserted.
- Outputs when count == 0: w, y, wa, wval and mask are all 0.
- Latency: a request pushed at edge N is at the head at the earliest in the cycle after N. There is no combinational in_* to w passthrough.
- Count update: count increments on push only, decrements on pop only, and is unchanged on a simultaneous push and pop.
  - At count=1, a push plus pop every cycle sustains 1 write/cycle.
- Ordering: strict FIFO; no merging or reordering of entries.
- empty = (count == 0).
- chk_hit (combinational) = 1 if any valid entry e, including the head entry being issued this cycle, satisfies e.wa == chk_a, or (e.wa < 8 and e.wa + 8 == chk_a).
  - A pending write to a>=8 does not hit probe a-8.
  - Invalid slots never contribute.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full versus empty is resolved by count.
- Reset: on rst=1, asynchronously set count=0, head=0, tail=0.
  - Consequently w=0, empty=1, in_ready=1 and chk_hit=0 immediately.
  - Entry storage need not be reset.
  - Pending entries are discarded when reset is asserted mid-operation; no stale write may issue after reset is released.
- in_* values are ignored when in_valid=0. Pushes during hold are accepted until full.

Test Plan:
- Reset: assert rst -> w=0, empty=1, in_ready=1, count=0, chk_hit=0 for chk_a=0..15.
- Single write: push {y=1, wa=3, wval=0xA5, mask=all ones} at edge 0.
  - Next cycle: w=1, wa=3, wval=0xA5, y=1.
  - After edge 1: empty=1, w=0.
- Backpressure and ordering: hold=1, push wa=1,2,3,4.
  - in_ready=0 and count=4; a fifth in_valid is not accepted.
  - Release hold: w=1 for 4 consecutive cycles issuing wa=1,2,3,4 in order.
  - in_ready=1 the cycle after the first pop.
- Hazard mirroring:
  - Pending wa=2: chk_a=2 -> 1, chk_a=10 -> 1, chk_a=3 -> 0.
  - Pending wa=9: chk_a=9 -> 1, chk_a=1 -> 0.
  - Hit stays 1 while hold=1 and clears after the entry pops.
- Streaming: in_valid=1 every cycle, hold=0, 8 requests -> w=1 for 8 consecutive cycles starting one cycle after the first push; count never exceeds 1.
- Mid-operation reset: 3 entries pending, assert rst asynchronously between edges -> w=0 and count=0 immediately; after release, no writes issue without new pushes.

Source files
------------

// File: rtl/breg_wbq.sv
// -----------------------------------------------------------------------------
// breg_wbq : writeback queue in front of the banked register file (breg).
//
// Buffers execute-stage write requests in a DEPTH-entry circular FIFO and drains
// at most one per cycle into breg's write port, strictly in order. It also flags
// read-after-write hazards for a probe address, taking breg's low-to-high
// mirroring into account (a write to a<8 lands on both a and a+8).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream request handshake
//   in_y, in_wa, in_wval,    request fields (mode, address, data, bit mask)
//   in_mask
//   hold                     stall draining (pushes still accepted)
//   w, y, wa, wval, mask     breg write port (head entry, zeros when empty)
//   chk_a / chk_hit          hazard probe address / pending-write indication
//   empty, count             occupancy status
// -----------------------------------------------------------------------------
`ifndef WORD
`define WORD 8
`endif

module breg_wbq #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_y,
    input  logic [3:0]                 in_wa,
    input  logic [`WORD-1:0]           in_wval,
    input  logic [`WORD-1:0]           in_mask,
    input  logic                       hold,
    output logic                       w,
    output logic                       y,
    output logic [3:0]                 wa,
    output logic [`WORD-1:0]           wval,
    output logic [`WORD-1:0]           mask,
    input  logic [3:0]                 chk_a,
    output logic                       chk_hit,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int W  = `WORD;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    // A pending write to 'e_wa' makes a read of 'probe' stale if it targets the
    // same register, or if it is a low register whose mirror image is 'probe'.
    // A high register is never mirrored downwards.
    function automatic logic wa_hazard(input logic [3:0] e_wa, input logic [3:0] probe);
        logic direct_v;
        logic mirror_v;
        direct_v = (e_wa == probe);
        mirror_v = (e_wa[3] == 1'b0) && ({1'b1, e_wa[2:0]} == probe);
        return direct_v || mirror_v;
    endfunction

    logic                y_mem_r    [DEPTH];
    logic [3:0]          wa_mem_r   [DEPTH];
    logic [W-1:0]        wval_mem_r [DEPTH];
    logic [W-1:0]        mask_mem_r [DEPTH];

    logic [AW-1:0]       head_r;
    logic [AW-1:0]       tail_r;
    logic [CW-1:0]       count_r;

    logic                push_s;
    logic                pop_s;
    logic                nonempty_s;
    logic                hit_s;

    assign nonempty_s = (count_r != CNT_ZERO);
    // Readiness depends only on registered occupancy, so a full queue refuses a
    // push even in a cycle where it also pops.
    assign in_ready   = (count_r < CNT_FULL);
    assign push_s     = in_valid && in_ready;
    assign pop_s      = nonempty_s && !hold;
    assign w          = pop_s;
    assign empty      = !nonempty_s;
    assign count      = count_r;
    assign chk_hit    = hit_s;

    // Entry storage: written at the tail on push; contents need no reset since
    // only slots covered by count are ever observed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            y_mem_r[tail_r]    <= in_y;
            wa_mem_r[tail_r]   <= in_wa;
            wval_mem_r[tail_r] <= in_wval;
            mask_mem_r[tail_r] <= in_mask;
        end
    end

    // Pointer and occupancy state; reset discards every pending entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // breg write port: head entry is shown even under hold; all zero when empty.
    always_comb begin
        y    = 1'b0;
        wa   = 4'd0;
        wval = {W{1'b0}};
        mask = {W{1'b0}};
        if (nonempty_s) begin
            y    = y_mem_r[head_r];
            wa   = wa_mem_r[head_r];
            wval = wval_mem_r[head_r];
            mask = mask_mem_r[head_r];
        end else begin
            y    = 1'b0;
            wa   = 4'd0;
            wval = {W{1'b0}};
            mask = {W{1'b0}};
        end
    end

    // Hazard probe: a slot is live when its distance from head (mod DEPTH) is
    // below count; the head entry being issued this cycle still counts.
    always_comb begin
        logic [AW-1:0] offset_v;
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset_v = AW'(i) - head_r;
            if ((CW'(offset_v) < count_r) && wa_hazard(wa_mem_r[i], chk_a)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

endmodule

// File: tb/tb_breg_wbq.sv
// -----------------------------------------------------------------------------
// tb_breg_wbq : directed self-checking bench for breg_wbq (DEPTH=4, 8-bit word).
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// well away from the rising (active) edge.
// -----------------------------------------------------------------------------
`ifndef WORD
`define WORD 8
`endif

module tb_breg_wbq;

    localparam int DEPTH = 4;
    localparam int W     = `WORD;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_y;
    logic [3:0]    in_wa;
    logic [W-1:0]  in_wval;
    logic [W-1:0]  in_mask;
    logic          hold;
    logic          w;
    logic          y;
    logic [3:0]    wa;
    logic [W-1:0]  wval;
    logic [W-1:0]  mask;
    logic [3:0]    chk_a;
    logic          chk_hit;
    logic          empty;
    logic [CW-1:0] count;

    int checks_r   = 0;
    int failures_r = 0;

    breg_wbq #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_y     (in_y),
        .in_wa    (in_wa),
        .in_wval  (in_wval),
        .in_mask  (in_mask),
        .hold     (hold),
        .w        (w),
        .y        (y),
        .wa       (wa),
        .wval     (wval),
        .mask     (mask),
        .chk_a    (chk_a),
        .chk_hit  (chk_hit),
        .empty    (empty),
        .count    (count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Move to the next falling edge (one full cycle has passed since the last).
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic v, input logic yy, input logic [3:0] a,
                           input logic [W-1:0] d, input logic [W-1:0] m);
        in_valid = v;
        in_y     = yy;
        in_wa    = a;
        in_wval  = d;
        in_mask  = m;
    endtask

    // Stimulus and checks.
    initial begin
        rst   = 1'b1;
        hold  = 1'b0;
        chk_a = 4'd0;
        set_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);

        // ---------------- reset state ----------------
        #1;
        check("rst_w",        32'(w),        32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count",    32'(count),    32'd0);
        for (int a = 0; a < 16; a++) begin
            chk_a = 4'(a);
            #1;
            check("rst_chk_hit", 32'(chk_hit), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // ---------------- single write ----------------
        set_req(1'b1, 1'b1, 4'd3, 8'hA5, 8'hFF);
        #1;
        check("single_no_passthru", 32'(w), 32'd0);
        next_cycle();
        set_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        #1;
        check("single_w",     32'(w),     32'd1);
        check("single_wa",    32'(wa),    32'd3);
        check("single_wval",  32'(wval),  32'hA5);
        check("single_y",     32'(y),     32'd1);
        check("single_mask",  32'(mask),  32'hFF);
        check("single_count", 32'(count), 32'd1);
        next_cycle();
        #1;
        check("single_empty", 32'(empty), 32'd1);
        check("single_w_off", 32'(w),     32'd0);
        check("single_wa_0",  32'(wa),    32'd0);
        check("single_wv_0",  32'(wval),  32'd0);

        // ---------------- backpressure and ordering ----------------
        @(negedge clk);
        hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_req(1'b1, 1'b0, 4'(k), 8'(8'h10 + k), 8'h0F);
            next_cycle();
        end
        set_req(1'b1, 1'b1, 4'd5, 8'hEE, 8'hEE);
        #1;
        check("full_in_ready",  32'(in_ready), 32'd0);
        check("full_count",     32'(count),    32'd4);
        check("full_hold_w",    32'(w),        32'd0);
        check("full_hold_head", 32'(wa),       32'd1);
        next_cycle();
        set_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        #1;
        check("full_reject_count", 32'(count), 32'd4);
        hold = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("drain_w",    32'(w),    32'd1);
            check("drain_wa",   32'(wa),   32'(k));
            check("drain_wval", 32'(wval), 32'(8'h10 + k));
            check("drain_y",    32'(y),    32'd0);
            if (k == 1) begin
                check("drain_full_ready", 32'(in_ready), 32'd0);
            end
            if (k == 2) begin
                check("drain_ready_back", 32'(in_ready), 32'd1);
            end
            next_cycle();
        end
        #1;
        check("drain_done_w",     32'(w),     32'd0);
        check("drain_done_empty", 32'(empty), 32'd1);

        // ---------------- hazard mirroring ----------------
        @(negedge clk);
        hold = 1'b1;
        set_req(1'b1, 1'b1, 4'd2, 8'h22, 8'hFF);
        next_cycle();
        set_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        chk_a = 4'd2;  #1; check("haz2_a2",  32'(chk_hit), 32'd1);
        chk_a = 4'd10; #1; check("haz2_a10", 32'(chk_hit), 32'd1);
        chk_a = 4'd3;  #1; check("haz2_a3",  32'(chk_hit), 32'd0);
        chk_a = 4'd2;
        next_cycle();
        #1;
        check("haz2_hold_keep", 32'(chk_hit), 32'd1);
        hold = 1'b0;
        #1;
        check("haz2_issuing_hit", 32'(chk_hit), 32'd1);
        next_cycle();
        #1;
        check("haz2_cleared", 32'(chk_hit), 32'd0);

        hold = 1'b1;
        set_req(1'b1, 1'b0, 4'd9, 8'h99, 8'hFF);
        next_cycle();
        set_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        chk_a = 4'd9; #1; check("haz9_a9", 32'(chk_hit), 32'd1);
        chk_a = 4'd1; #1; check("haz9_a1", 32'(chk_hit), 32'd0);
        chk_a = 4'd9;
        next_cycle();
        #1;
        check("haz9_hold_keep", 32'(chk_hit), 32'd1);
        hold = 1'b0;
        next_cycle();
        #1;
        check("haz9_cleared", 32'(chk_hit), 32'd0);

        // ---------------- streaming ----------------
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, 1'(i), 4'(i), 8'(8'h40 + i), 8'hF0);
            #1;
            check("stream_count", 32'(count),    (i == 0) ? 32'd0 : 32'd1);
            check("stream_ready", 32'(in_ready), 32'd1);
            if (i > 0) begin
                check("stream_w",    32'(w),    32'd1);
                check("stream_wa",   32'(wa),   32'(i - 1));
                check("stream_wval", 32'(wval), 32'(8'h40 + i - 1));
            end else begin
                check("stream_first_w", 32'(w), 32'd0);
            end
            next_cycle();
        end
        set_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        #1;
        check("stream_last_w",  32'(w),  32'd1);
        check("stream_last_wa", 32'(wa), 32'd7);
        check("stream_last_y",  32'(y),  32'd1);
        next_cycle();
        #1;
        check("stream_empty", 32'(empty), 32'd1);

        // ---------------- mid-operation reset ----------------
        @(negedge clk);
        hold = 1'b1;
        for (int k = 5; k <= 7; k++) begin
            set_req(1'b1, 1'b1, 4'(k), 8'(k), 8'hFF);
            next_cycle();
        end
        set_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        hold  = 1'b0;
        chk_a = 4'd6;
        #1;
        check("mid_count_pre", 32'(count), 32'd3);
        check("mid_w_pre",     32'(w),     32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_w",     32'(w),        32'd0);
        check("mid_rst_count", 32'(count),    32'd0);
        check("mid_rst_empty", 32'(empty),    32'd1);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_hit",   32'(chk_hit),  32'd0);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("post_rst_no_w", 32'(w),     32'd0);
            check("post_rst_cnt",  32'(count), 32'd0);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
